// File: rtl/tdp_ram_arbiter.sv
// tdp_ram_arbiter
// Round-robin arbiter that lets NUM_REQ requesters share both ports of an
// external true dual-port RAM. Up to two requests are accepted per cycle
// (port A, then port B). Accepted requests are registered onto the RAM ports
// one cycle later. A fixed-latency tag pipeline routes read data back to the
// requester that issued the read.

package tdp_ram_arbiter_pkg;

  // Number of bits needed to represent 'value' (RAM template style clogb2).
  function automatic int clogb2(input int value);
    int v;
    int bits;
    v    = value;
    bits = 0;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    return bits;
  endfunction

endpackage

module tdp_ram_arbiter
  import tdp_ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,     // 2..8
  parameter int RAM_WIDTH    = 18,
  parameter int RAM_DEPTH    = 1024,
  parameter int READ_LATENCY = 2,     // 1 = LOW_LATENCY, 2 = HIGH_PERFORMANCE
  localparam int AW          = clogb2(RAM_DEPTH - 1)
) (
  input  logic                           clka,
  input  logic                           rsta,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*AW-1:0]          req_addr,
  input  logic [NUM_REQ*RAM_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [NUM_REQ*RAM_WIDTH-1:0]   rsp_rdata,
  output logic                           ram_ena,
  output logic                           ram_wea,
  output logic                           ram_enb,
  output logic                           ram_web,
  output logic [AW-1:0]                  ram_addra,
  output logic [AW-1:0]                  ram_addrb,
  output logic [RAM_WIDTH-1:0]           ram_dina,
  output logic [RAM_WIDTH-1:0]           ram_dinb,
  input  logic [RAM_WIDTH-1:0]           ram_douta,
  input  logic [RAM_WIDTH-1:0]           ram_doutb
);

  // Requester index width and tag pipeline depth (RAM port register stage
  // plus READ_LATENCY RAM stages).
  localparam int PW = clogb2(NUM_REQ - 1);
  localparam int TS = READ_LATENCY + 1;

  typedef logic [PW-1:0] idx_t;

  // Contents of one RAM port register.
  typedef struct packed {
    logic                 en;
    logic                 we;
    logic [AW-1:0]        addr;
    logic [RAM_WIDTH-1:0] din;
  } port_t;

  // One tag stage: is there a read in flight, and who issued it.
  typedef struct packed {
    logic vld;
    idx_t idx;
  } tag_t;

  logic [AW-1:0]        addr_arr  [NUM_REQ];
  logic [RAM_WIDTH-1:0] wdata_arr [NUM_REQ];

  idx_t  rr_ptr_q, rr_ptr_d;
  logic  a_found, b_found;
  idx_t  a_idx, b_idx;
  logic  b_conflict;
  logic  a_grant, b_grant;

  port_t port_a_q, port_a_d;
  port_t port_b_q, port_b_d;

  tag_t  tag_a_q [TS];
  tag_t  tag_a_d [TS];
  tag_t  tag_b_q [TS];
  tag_t  tag_b_d [TS];

  // (base + step) mod NUM_REQ; callers keep base < NUM_REQ and step < NUM_REQ.
  function automatic idx_t wrap_inc(input idx_t base, input int unsigned step);
    int unsigned sum;
    sum = 32'(base) + step;
    if (sum >= 32'(NUM_REQ)) begin
      sum = sum - 32'(NUM_REQ);
    end
    return idx_t'(sum);
  endfunction

  // Split the flat request buses into per-requester fields.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      addr_arr[k]  = req_addr[k*AW +: AW];
      wdata_arr[k] = req_wdata[k*RAM_WIDTH +: RAM_WIDTH];
    end
  end

  // Scan cyclically from rr_ptr: first valid requester is the A candidate,
  // the next valid one after it is the B candidate.
  always_comb begin : pick
    idx_t cand;
    // NOTE: every output of this block gets a default before the scan, so no
    // path through the loop can leave a value held (no latch).
    a_found = 1'b0;
    b_found = 1'b0;
    a_idx   = '0;
    b_idx   = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrap_inc(rr_ptr_q, unsigned'(k));
      if (req_valid[cand]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = cand;
        end else if (!b_found) begin
          b_found = 1'b1;
          b_idx   = cand;
        end
      end
    end
  end

  // Same-address hazard: B is held off when it hits A's address and either is
  // a write; two reads may share an address. Nothing is granted during reset.
  always_comb begin
    b_conflict = b_found && (addr_arr[b_idx] == addr_arr[a_idx]) &&
                 (req_we[a_idx] || req_we[b_idx]);
    a_grant    = a_found && !rsta;
    b_grant    = b_found && !b_conflict && !rsta;
    req_ready  = '0;
    if (a_grant) req_ready[a_idx] = 1'b1;
    if (b_grant) req_ready[b_idx] = 1'b1;
  end

  // Next pointer, RAM port register and tag stage values.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (b_grant) begin
      rr_ptr_d = wrap_inc(b_idx, 1);
    end else if (a_grant) begin
      rr_ptr_d = wrap_inc(a_idx, 1);
    end

    port_a_d = '0;
    if (a_grant) begin
      port_a_d.en   = 1'b1;
      port_a_d.we   = req_we[a_idx];
      port_a_d.addr = addr_arr[a_idx];
      port_a_d.din  = wdata_arr[a_idx];
    end

    port_b_d = '0;
    if (b_grant) begin
      port_b_d.en   = 1'b1;
      port_b_d.we   = req_we[b_idx];
      port_b_d.addr = addr_arr[b_idx];
      port_b_d.din  = wdata_arr[b_idx];
    end

    // Writes enter the pipeline as invalid so their read-first data is dropped.
    tag_a_d[0].vld = a_grant && !req_we[a_idx];
    tag_a_d[0].idx = a_idx;
    tag_b_d[0].vld = b_grant && !req_we[b_idx];
    tag_b_d[0].idx = b_idx;
    for (int s = 1; s < TS; s++) begin
      tag_a_d[s] = tag_a_q[s-1];
      tag_b_d[s] = tag_b_q[s-1];
    end
  end

  // State registers; reset clears the pointer, both port registers and every
  // tag stage, which discards all reads still in flight.
  always_ff @(posedge clka or posedge rsta) begin
    // NOTE: non-blocking assignments, so each flop captures the pre-edge value
    // of every other flop regardless of statement order.
    if (rsta) begin
      rr_ptr_q <= '0;
      port_a_q <= '0;
      port_b_q <= '0;
      // NOTE: tag stages are reset (unlike the RAM contents) because their
      // valid bits alone decide whether rsp_valid fires.
      for (int s = 0; s < TS; s++) begin
        tag_a_q[s] <= '0;
        tag_b_q[s] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      port_a_q <= port_a_d;
      port_b_q <= port_b_d;
      for (int s = 0; s < TS; s++) begin
        tag_a_q[s] <= tag_a_d[s];
        tag_b_q[s] <= tag_b_d[s];
      end
    end
  end

  // RAM port outputs come straight from the port registers.
  assign ram_ena   = port_a_q.en;
  assign ram_wea   = port_a_q.we;
  assign ram_addra = port_a_q.addr;
  assign ram_dina  = port_a_q.din;
  assign ram_enb   = port_b_q.en;
  assign ram_web   = port_b_q.we;
  assign ram_addrb = port_b_q.addr;
  assign ram_dinb  = port_b_q.din;

  // Route RAM output data to the requester named by each port's last tag
  // stage; a requester holds at most one grant per cycle, so at most one port
  // can match it. Data is zero whenever valid is low.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag_a_q[TS-1].vld && (tag_a_q[TS-1].idx == idx_t'(i))) begin
        rsp_valid[i]                             = 1'b1;
        rsp_rdata[i*RAM_WIDTH +: RAM_WIDTH]      = ram_douta;
      end else if (tag_b_q[TS-1].vld && (tag_b_q[TS-1].idx == idx_t'(i))) begin
        rsp_valid[i]                             = 1'b1;
        rsp_rdata[i*RAM_WIDTH +: RAM_WIDTH]      = ram_doutb;
      end
    end
  end

endmodule
